// File: rtl/cordic_sched_if.sv
// Requester and CORDIC-engine handshake bundle for cordic_sched.
// The slave modport is the scheduler. The master modport is the requesters plus the engine.
interface cordic_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_mode;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              cdc_start;
  logic [1:0]        cdc_mode;
  logic              cdc_finish;

  modport master (
    output req, req_mode, cdc_finish,
    input  ack, done, err, cdc_start, cdc_mode
  );

  modport slave (
    input  req, req_mode, cdc_finish,
    output ack, done, err, cdc_start, cdc_mode
  );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin scheduler that shares one cordic_top engine between NREQ requesters.
// Optional BUSY watchdog is built when CORDIC_SCHED_TIMEOUT_EN is defined.
module cordic_sched #(
  parameter int NREQ    = 4,
  parameter int IW      = 2,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  cordic_sched_if.slave       bus,
  output logic                busy,
  output logic [IW-1:0]       owner,
  output logic [CW-1:0]       job_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] rr_ptr_r, rr_next_s;
  logic [IW-1:0] win_s, owner_s;
  logic [1:0]    mode_r, mode_s;
  logic          err_r, err_s;
  logic          tmo_hit_s;

  // First set request bit at or above ptr, wrapping modulo NREQ.
  function automatic logic [IW-1:0] pick_winner(input logic [NREQ-1:0] r, input logic [IW-1:0] ptr);
    logic [IW-1:0] win;
    logic          found;
    int            idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && r[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_r;

  // BUSY cycle counter; zero on every cycle outside BUSY, so it clears on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= {TW{1'b0}};
    end else if (state_r == ST_BUSY) begin
      tmo_r <= tmo_r + TW'(1);
    end else begin
      tmo_r <= {TW{1'b0}};
    end
  end

  assign tmo_hit_s = (tmo_r == TW'(TIMEOUT - 1));
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic [31:0] tmo_unused_s;
  assign tmo_unused_s = 32'(TIMEOUT);
  assign tmo_hit_s    = 1'b0;
`endif

  assign win_s     = pick_winner(bus.req, rr_ptr_r);
  assign rr_next_s = (owner == IW'(NREQ - 1)) ? {IW{1'b0}} : owner + IW'(1);

  // Next-state and latched job attributes.
  always_comb begin
    state_s = state_r;
    owner_s = owner;
    mode_s  = mode_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req != {NREQ{1'b0}}) begin
          owner_s = win_s;
          mode_s  = bus.req_mode[{win_s, 1'b0} +: 2];
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (mode_r == 2'b11) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          err_s   = 1'b0;
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: state_s = ST_BUSY;
      ST_BUSY: begin
        if (bus.cdc_finish) begin
          err_s   = 1'b0;
          state_s = ST_DONE;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State and every output is registered from the next state, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      owner         <= {IW{1'b0}};
      mode_r        <= 2'b00;
      err_r         <= 1'b0;
      rr_ptr_r      <= {IW{1'b0}};
      job_cnt       <= {CW{1'b0}};
      busy          <= 1'b0;
      bus.ack       <= {NREQ{1'b0}};
      bus.done      <= {NREQ{1'b0}};
      bus.err       <= 1'b0;
      bus.cdc_start <= 1'b0;
    end else begin
      state_r       <= state_s;
      owner         <= owner_s;
      mode_r        <= mode_s;
      err_r         <= err_s;
      busy          <= (state_s != ST_IDLE);
      bus.ack       <= (state_s == ST_GRANT) ? onehot(owner_s) : {NREQ{1'b0}};
      bus.done      <= (state_s == ST_DONE) ? onehot(owner_s) : {NREQ{1'b0}};
      bus.err       <= (state_s == ST_DONE) ? err_s : 1'b0;
      bus.cdc_start <= (state_s == ST_ISSUE);
      if (state_r == ST_DONE) begin
        rr_ptr_r <= rr_next_s;
        job_cnt  <= err_r ? job_cnt : job_cnt + CW'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
        job_cnt  <= job_cnt;
      end
    end
  end

  assign bus.cdc_mode = mode_r;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed plus randomized bench for cordic_sched, checked against a round-robin job model.
module tb_cordic_sched;
  localparam int NREQ = 4;
  localparam int IW   = 2;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [IW-1:0] owner;
  logic [CW-1:0] job_cnt;

  int n_asrt = 0;
  int n_fail = 0;
  int m_rr   = 0;
  int m_cnt  = 0;

  cordic_sched_if #(.NREQ(NREQ)) bus();

  cordic_sched #(.NREQ(NREQ), .IW(IW), .CW(CW), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .owner(owner), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r, input int rr);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(rr + i) % NREQ]) return (rr + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [31:0] bit_of(input int k);
    return 32'd1 << k;
  endfunction

  // One whole job from an IDLE cycle with requests pending; pin_own >= 0 also pins the expected owner.
  task automatic do_job(input int fin_delay, input int pin_own);
    int         exp_own;
    logic [1:0] exp_mode;
    int         k;
    exp_own  = model_pick(bus.req, m_rr);
    exp_mode = bus.req_mode[2*exp_own +: 2];
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.ack == 4'b0000 && k < 6);
    chk("ack_lat", k, 1);
    chk("ack", bus.ack, bit_of(exp_own));
    chk("owner", owner, exp_own);
    if (pin_own >= 0) chk("order", owner, pin_own);
    chk("busy", busy, 1);
    bus.req[exp_own] = 1'b0;
    if (exp_mode == 2'b11) begin
      tick();
      chk("rej_start", bus.cdc_start, 0);
      chk("rej_done", bus.done, bit_of(exp_own));
      chk("rej_err", bus.err, 1);
    end else begin
      tick();
      chk("start", bus.cdc_start, 1);
      chk("mode_issue", bus.cdc_mode, exp_mode);
      chk("ack_once", bus.ack, 0);
      tick();
      for (int d = 0; d < fin_delay; d++) begin
        chk("busy_nostart", bus.cdc_start, 0);
        chk("busy_mode", bus.cdc_mode, exp_mode);
        tick();
      end
      bus.cdc_finish = 1'b1;
      tick();
      bus.cdc_finish = 1'b0;
      chk("done", bus.done, bit_of(exp_own));
      chk("done_err", bus.err, 0);
      chk("done_mode", bus.cdc_mode, exp_mode);
      m_cnt++;
    end
    tick();
    chk("done_once", bus.done, 0);
    chk("idle_busy", busy, 0);
    chk("job_cnt", job_cnt, m_cnt);
    m_rr = (exp_own + 1) % NREQ;
  endtask

  initial begin
    bus.req        = 4'b0000;
    bus.req_mode   = 8'h00;
    bus.cdc_finish = 1'b0;
    repeat (2) tick();
    chk("rst_ack", bus.ack, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_cnt", job_cnt, 0);
    chk("rst_start", bus.cdc_start, 0);
    chk("rst_mode", bus.cdc_mode, 0);
    rst_n = 1'b1;
    tick();

    // single request, long job
    bus.req_mode = 8'b00_00_00_01;
    bus.req      = 4'b0001;
    do_job(19, 0);
    chk("mode_hold_idle", bus.cdc_mode, 2'b01);

    // invalid mode is rejected but still advances the pointer
    bus.req_mode = 8'b00_11_00_00;
    bus.req      = 4'b0100;
    do_job(0, 2);

    // wrap from pointer 3
    bus.req_mode = 8'b10_00_00_01;
    bus.req      = 4'b1001;
    do_job(3, 3);
    do_job(5, 0);

    // reset in the middle of BUSY
    bus.req_mode = 8'b00_00_10_00;
    bus.req      = 4'b0010;
    tick();
    chk("mid_ack", bus.ack, 4'b0010);
    bus.req = 4'b0000;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_owner", owner, 0);
    chk("arst_cnt", job_cnt, 0);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("arst_nodone", bus.done, 0);
    end
    rst_n = 1'b1;
    m_rr  = 0;
    m_cnt = 0;
    bus.cdc_finish = 1'b1;
    tick();
    bus.cdc_finish = 1'b0;
    tick();
    chk("stale_fin_done", bus.done, 0);
    chk("stale_fin_busy", busy, 0);

    // full contention, each requester drops after its ack
    bus.req_mode = 8'b01_10_00_10;
    bus.req      = 4'b1111;
    for (int j = 0; j < NREQ; j++) do_job(j + 1, j);

    // randomized request sets and modes
    for (int it = 0; it < 12; it++) begin
      bus.req_mode = 8'($urandom);
      bus.req      = 4'($urandom_range(1, 15));
      while (bus.req != 4'b0000) do_job(int'($urandom_range(0, 6)), -1);
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    bus.req_mode = 8'b00_00_00_10;
    bus.req      = 4'b0001;
    tick();
    chk("tmo_ack", bus.ack, bit_of(model_pick(4'b0001, m_rr)));
    bus.req = 4'b0000;
    tick();
    tick();
    for (int j = 1; j < 64; j++) begin
      chk("tmo_wait", bus.done, 0);
      tick();
    end
    chk("tmo_done", bus.done, 4'b0001);
    chk("tmo_err", bus.err, 1);
    bus.cdc_finish = 1'b1;
    tick();
    bus.cdc_finish = 1'b0;
    tick();
    chk("tmo_late_done", bus.done, 0);
    chk("tmo_cnt", job_cnt, m_cnt);
    m_rr = 1;
`endif

    chk("final_cnt", job_cnt, m_cnt);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Round-robin scheduler that shares one cordic_top engine between NREQ requesters.
- Each requester asks for one whole-buffer CORDIC pass in a chosen mode.
- The scheduler grants one requester at a time, drives cordic_top `start`/`mode`, and holds `mode` stable for the entire pass.
- It waits for `finish`, then returns a completion pulse to the owner.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IW, 2, width of owner index; must satisfy 2**IW >= NREQ.
- CW, 16, width of completed-job counter.
- TIMEOUT, 4096, BUSY-state cycle limit (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level; held high until ack.
- req_mode  input  2*NREQ  mode for requester i at bits [2i+1:2i].
- ack  output  NREQ  one-cycle grant pulse to the owner.
- done  output  NREQ  one-cycle completion pulse to the owner.
- err  output  1  qualifies `done`: 1 = job rejected or aborted.
- busy  output  1  high whenever state is not IDLE.
- owner  output  IW  index of current or last owner.
- job_cnt  output  CW  count of successfully completed jobs; wraps.
- cdc_start  output  1  to cordic_top `start`.
- cdc_mode  output  2  to cordic_top `mode`.
- cdc_finish  input  1  from cordic_top `finish`.

Behaviour:
- Reset values: ack=0, done=0, err=0, busy=0, owner=0, job_cnt=0, cdc_start=0, cdc_mode=2'b00, rr_ptr=0, state=IDLE.
- All outputs are registered or decoded from state (Moore); there are no combinational paths from input to output.

States:
- IDLE:
  - If req != 0, pick the winner: the first set bit of req scanning from rr_ptr upward, wrapping modulo NREQ.
  - Latch owner and mode_r = req_mode[owner].
  - Go to GRANT. If req == 0, stay in IDLE.
- GRANT:
  - ack[owner]=1 for this cycle only.
  - If mode_r == 2'b11 (invalid): go to DONE with err_r=1.
  - Otherwise go to ISSUE.
- ISSUE:
  - cdc_start=1 for exactly one cycle, then go to BUSY.
- BUSY:
  - Wait for cdc_finish=1, then go to DONE with err_r=0.
- DONE:
  - done[owner]=1 and err=err_r for one cycle.
  - rr_ptr = (owner+1) mod NREQ.
  - job_cnt += 1 only if err_r=0.
  - Go to IDLE.

Timing and boundary rules:
- cdc_mode = mode_r from GRANT through DONE inclusive; it does not change until the next grant.
- Minimum latency from req sampled in IDLE: ack at +1, cdc_start at +2, done at finish+1.
- cdc_finish is ignored outside BUSY.
- A request dropped before being sampled in IDLE is lost without ack.
- Once latched, a job completes even if req drops.
- req still high in the cycle after ack is treated as a new request.
- Simultaneous requests: exactly one ack per arbitration. A losing requester is served within NREQ-1 subsequent jobs (starvation-free).
- Only one of ack/done is ever high, and only for the owner.
- rr_ptr advances on rejected jobs too.
- job_cnt wraps from all-ones to 0.
- rst_n asserted mid-job returns everything to reset values immediately; no done is issued for the aborted job.

Optional Feature:
- Macro: CORDIC_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT-1 without cdc_finish, go to DONE with err_r=1; job_cnt is not incremented.
  - A late cdc_finish is ignored, since it arrives outside BUSY.
- Undefined:
  - No counter logic is present, and BUSY waits indefinitely for cdc_finish.

Test Plan:
- Single request: req=4'b0001, mode 2'b01 → ack[0] at +1, cdc_start at +2 with cdc_mode=01, finish after 20 cycles → done[0]=1, err=0, job_cnt=1, rr_ptr=1.
- Contention: req=4'b1111 held, each requester dropping its bit after its ack → grant order 0,1,2,3, and cdc_mode tracks each requester's mode for the whole of its job.
- Round-robin wrap: rr_ptr=3, req=4'b1001 → owner 3 first, then 0 → rr_ptr=1.
- Invalid mode: req[2] with mode 2'b11 → ack[2], then done[2] with err=1; cdc_start never asserts and job_cnt is unchanged.
- Reset mid-BUSY: rst_n low for 2 cycles → busy=0, owner=0, job_cnt=0, no done pulse, and a new request is served normally.
- With CORDIC_SCHED_TIMEOUT_EN and TIMEOUT=64, finish withheld → done with err=1 exactly 64 BUSY cycles after entry; a later finish pulse has no effect.
